// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-slot TDM demultiplexer.
//   tdm_state_e       : framer state encoding (HUNT=0, LOCKED=1)
//   SLOT_COUNT        : slots per frame
//   SLOT_W            : width of the slot index
//   SYNC_LOSS_MAX_DEF : default count of consecutive sync errors before re-hunting
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_e;

  localparam int SLOT_COUNT        = 4;
  localparam int SLOT_W            = 2;
  localparam int SYNC_LOSS_MAX_DEF = 2;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Modulo-4 slot counter for the TDM demultiplexer.
//   clk, rst_n : clock, asynchronous active-low reset
//   adv        : advance one slot (3 wraps to 0)
//   load1      : force slot to 1 (a sync beat was just stored as slot 0)
//   clr        : force slot to 0 (highest priority)
//   slot       : current slot index
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic              load1,
  input  logic              clr,
  output logic [SLOT_W-1:0] slot
);

  // The counter is exactly SLOT_W bits wide, so the modulo-4 wrap is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (clr) begin
      slot <= '0;
    end else if (load1) begin
      slot <= SLOT_W'(1);
    end else if (adv) begin
      slot <= slot + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// Serial 4-slot TDM demultiplexer with sync-based frame alignment.
//   clk, rst_n   : clock, asynchronous active-low reset
//   din          : serial data bit
//   din_valid    : qualifies din and sync; idle cycles are ignored
//   sync         : marks the slot-0 beat of a frame
//   y0..y3       : last complete frame, slots 0..3 (held between frames)
//   s1, s0       : slot expected on the next accepted beat (00 while hunting)
//   frame_valid  : one-cycle pulse when y0..y3 update
//   locked       : high while LOCKED; this is the framer state itself
//   sync_err     : one-cycle pulse on a misplaced or missing sync
//   frame_cnt    : 8-bit completed-frame counter, present only when
//                  TDM_DEMUX4_FRAME_CNT_EN is defined
//
// Handshake: a beat is accepted on a rising clk edge where din_valid=1; there
// is no back-pressure, and every registered output changes only on an
// accepted beat except the frame_valid/sync_err pulses, which clear on the
// following edge.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int SYNC_LOSS_MAX = SYNC_LOSS_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic       din_valid,
  input  logic       sync,
  output logic       y0,
  output logic       y1,
  output logic       y2,
  output logic       y3,
  output logic       s1,
  output logic       s0,
  output logic       frame_valid,
  output logic       locked,
`ifdef TDM_DEMUX4_FRAME_CNT_EN
  output logic [7:0] frame_cnt,
`endif
  output logic       sync_err
);

  tdm_state_e              state;
  logic [SLOT_W-1:0]       slot;
  logic [SLOT_COUNT-1:0]   shadow;
  logic [SLOT_COUNT-1:0]   y_q;
  logic [2:0]              err_cnt;
  logic [2:0]              err_inc;
  logic                    bad;
  logic                    lose;
  logic                    slot_adv;
  logic                    slot_load1;
  logic                    slot_clr;

  // A sync error is a sync at a non-zero slot, or a missing sync at slot 0.
  // Neither applies while hunting, where non-sync beats are simply dropped.
  always_comb begin
    err_inc    = err_cnt + 3'd1;
    bad        = (state == LOCKED) && (sync != (slot == '0));
    lose       = bad && (err_inc >= 3'(SYNC_LOSS_MAX));
    slot_adv   = 1'b0;
    slot_load1 = 1'b0;
    slot_clr   = 1'b0;
    if (din_valid) begin
      if (lose) begin
        slot_clr = 1'b1;
      end else if (sync) begin
        slot_load1 = 1'b1;
      end else if (state == LOCKED) begin
        slot_adv = 1'b1;
      end
    end
  end

  tdm_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (slot_adv),
    .load1 (slot_load1),
    .clr   (slot_clr),
    .slot  (slot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      shadow      <= '0;
      y_q         <= '0;
      err_cnt     <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
`ifdef TDM_DEMUX4_FRAME_CNT_EN
      frame_cnt   <= '0;
`endif
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (din_valid) begin
        sync_err <= bad;
        if (lose) begin
          state   <= HUNT;
          shadow  <= '0;
          err_cnt <= '0;
`ifdef TDM_DEMUX4_FRAME_CNT_EN
          frame_cnt <= '0;
`endif
        end else if (sync) begin
          // Sync always (re)starts a frame; any partial frame is discarded.
          state   <= LOCKED;
          shadow  <= {{(SLOT_COUNT-1){1'b0}}, din};
          err_cnt <= bad ? err_inc : 3'd0;
        end else if (state == LOCKED) begin
          shadow[slot] <= din;
          if (bad) begin
            err_cnt <= err_inc;
          end
          if (slot == SLOT_W'(SLOT_COUNT - 1)) begin
            // The slot-3 bit goes straight to the output, bypassing shadow.
            y_q         <= {din, shadow[2:0]};
            frame_valid <= 1'b1;
`ifdef TDM_DEMUX4_FRAME_CNT_EN
            frame_cnt   <= frame_cnt + 8'd1;
`endif
          end
        end
      end
    end
  end

  assign {y3, y2, y1, y0} = y_q;
  assign {s1, s0}         = slot;
  assign locked           = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
module tb_tdm_demux4;

  localparam int LOSS = 2;

  logic clk;
  logic rst_n;
  logic din;
  logic din_valid;
  logic sync;
  logic y0, y1, y2, y3;
  logic s1, s0;
  logic frame_valid;
  logic locked;
  logic sync_err;
`ifdef TDM_DEMUX4_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif

  tdm_demux4 #(.SYNC_LOSS_MAX(LOSS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .sync        (sync),
    .y0          (y0),
    .y1          (y1),
    .y2          (y2),
    .y3          (y3),
    .s1          (s1),
    .s0          (s0),
    .frame_valid (frame_valid),
    .locked      (locked),
`ifdef TDM_DEMUX4_FRAME_CNT_EN
    .frame_cnt   (frame_cnt),
`endif
    .sync_err    (sync_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [3:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Framing seen as "bits collected since the last sync": the expected slot
  // is the number of collected bits, a frame is complete at four bits.
  bit         m_hunt;
  bit         m_q[$];
  int         m_err;
  logic [3:0] m_y;
  bit         m_fv;
  bit         m_se;
  int         m_fcnt;

  task automatic model_reset();
    m_hunt = 1'b1;
    m_q.delete();
    m_err  = 0;
    m_y    = 4'h0;
    m_fv   = 1'b0;
    m_se   = 1'b0;
    m_fcnt = 0;
    exp_q.delete();
  endtask

  task automatic model_beat(input bit v, input bit s, input bit d);
    int pos;
    m_fv = 1'b0;
    m_se = 1'b0;
    if (!v) return;
    pos = m_q.size();
    if (m_hunt) begin
      if (s) begin
        m_q.delete();
        m_q.push_back(d);
        m_hunt = 1'b0;
        m_err  = 0;
      end
    end else begin
      if (s || pos == 0) begin
        if (s && pos == 0) m_err = 0;
        else begin
          m_err++;
          m_se = 1'b1;
        end
        m_q.delete();
        m_q.push_back(d);
      end else begin
        m_q.push_back(d);
        if (m_q.size() == 4) begin
          m_y = {m_q[3], m_q[2], m_q[1], m_q[0]};
          m_fv = 1'b1;
          exp_q.push_back(m_y);
          m_q.delete();
          m_fcnt = (m_fcnt + 1) % 256;
        end
      end
      if (m_err >= LOSS) begin
        m_hunt = 1'b1;
        m_q.delete();
        m_err  = 0;
        m_fcnt = 0;
      end
    end
  endtask

  function automatic int m_slot();
    return m_hunt ? 0 : m_q.size();
  endfunction

  task automatic compare_outputs();
    chk("locked", 32'(locked), 32'(!m_hunt));
    chk("slot", 32'({s1, s0}), 32'(m_slot()));
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    chk("sync_err", 32'(sync_err), 32'(m_se));
    chk("y", 32'({y3, y2, y1, y0}), 32'(m_y));
    if (frame_valid) begin
      if (exp_q.size() == 0) chk("frame_unexpected", 32'({y3, y2, y1, y0}), 32'hdead);
      else chk("frame", 32'({y3, y2, y1, y0}), 32'(exp_q.pop_front()));
    end
`ifdef TDM_DEMUX4_FRAME_CNT_EN
    chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the following negedge after checking.
  task automatic step(input bit v, input bit s, input bit d);
    din_valid = v;
    sync      = s;
    din       = d;
    @(posedge clk);
    model_beat(v, s, d);
    @(negedge clk);
    compare_outputs();
  endtask

  // Four beats, sync on the first, din[k] goes to slot k.
  task automatic frame(input logic [3:0] d);
    for (int k = 0; k < 4; k++) step(1'b1, k == 0, d[k]);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_y"}, 32'({y3, y2, y1, y0}), 32'h0);
    chk({tag, "_slot"}, 32'({s1, s0}), 32'h0);
    chk({tag, "_flags"}, 32'({frame_valid, sync_err, locked}), 32'h0);
`ifdef TDM_DEMUX4_FRAME_CNT_EN
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'h0);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit s;
    rst_n     = 1'b0;
    din       = 1'b0;
    din_valid = 1'b0;
    sync      = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Beats without sync are ignored while hunting.
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);

    // First frame 1,0,1,0 -> y0..y3 = 1,0,1,0.
    frame(4'b0101);
    chk("first_frame", 32'({y3, y2, y1, y0}), 32'h5);

    // Back-to-back frames.
    frame(4'b0011);
    frame(4'b1110);
    chk("b2b_frame", 32'({y3, y2, y1, y0}), 32'he);

    // Idle gaps between beats of a frame.
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("gap_frame", 32'({y3, y2, y1, y0}), 32'hb);

    // Sync arriving at slot 2 restarts the frame.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    frame(4'b0110);
    chk("resync_frame", 32'({y3, y2, y1, y0}), 32'h6);

    // Two frames without sync at slot 0 -> loss of lock, then ignored beats.
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, k[0]);
    chk("lost_lock", 32'(locked), 32'h0);
    frame(4'b1001);

    // Reset in mid-frame.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    frame(4'b1100);

`ifdef TDM_DEMUX4_FRAME_CNT_EN
    for (int f = 0; f < 255; f++) frame(4'($urandom_range(0, 15)));
    chk("frame_cnt_wrap", 32'(frame_cnt), 32'h0);
`endif

    // Randomised traffic: mostly well-formed, with sprinkled sync faults.
    for (int i = 0; i < 600; i++) begin
      if (m_hunt) s = ($urandom_range(0, 3) == 0);
      else if (m_slot() == 0) s = ($urandom_range(0, 9) != 0);
      else s = ($urandom_range(0, 19) == 0);
      step($urandom_range(0, 4) != 0, s, 1'($urandom_range(0, 1)));
    end

    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
